// File: rtl/prbs_pkg.sv
// Shared types and default constants for the PRBS burst sequencer.
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } burst_state_e;

    localparam int DEF_OS      = 4;
    localparam int DEF_PRE_LEN = 8;
    localparam int DEF_LEN_W   = 16;

    localparam logic [4:0] PRBS5_SEED = 5'b00001;

endpackage

// File: rtl/sym_tick_div.sv
// Symbol-period divider: counts 0..OS-1 while enabled and flags the last cycle.
module sym_tick_div #(
    parameter int OS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int DIV_W = $clog2(OS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS - 1);

    logic [DIV_W-1:0] div_r;

    assign tick = (div_r == DIV_LAST);

    // Divider counter; clear has priority so a new burst always starts at phase 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= {DIV_W{1'b0}};
        end else if (clr) begin
            div_r <= {DIV_W{1'b0}};
        end else if (en) begin
            if (tick) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end else begin
            div_r <= div_r;
        end
    end

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Burst framing for the PRBS5 test-pattern generator: preamble, payload, gap,
// one symbol per OS clocks, with one-shot, continuous and abort control.
module prbs_burst_ctrl
    import prbs_pkg::*;
#(
    parameter int OS      = DEF_OS,
    parameter int PRE_LEN = DEF_PRE_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_continuous,
    input  logic [LEN_W-1:0] i_burst_len,
    input  logic [LEN_W-1:0] i_gap_len,
    input  logic             i_prbs,
    output logic             o_gen_en,
    output logic             o_sym,
    output logic             o_sym_valid,
    output logic             o_sym_is_pre,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_sym_cnt
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PRE_LEN - 1);

    burst_state_e     state_r;
    burst_state_e     eob_state_s;
    burst_state_e     pre_next_s;
    burst_state_e     pay_next_s;
    logic [LEN_W-1:0] sym_cnt_r;
    logic [LEN_W-1:0] burst_len_r;
    logic [LEN_W-1:0] gap_len_r;
    logic             continuous_r;
    logic             tick_s;
    logic             start_ok_s;
    logic             div_clr_s;
    logic             div_en_s;

    assign start_ok_s = (state_r == IDLE) && i_start && !i_abort;
    assign div_clr_s  = i_abort || start_ok_s;
    assign div_en_s   = (state_r != IDLE);

    sym_tick_div #(
        .OS (OS)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr_s),
        .en   (div_en_s),
        .tick (tick_s)
    );

    // Generator enable is decoded from registers only so it never sees input glitches
    assign o_gen_en  = tick_s && (state_r == PAY);
    assign o_busy    = (state_r != IDLE);
    assign o_sym_cnt = sym_cnt_r;

    // Phase successors; empty phases are skipped straight to end-of-burst
    always_comb begin
        if (continuous_r) begin
            eob_state_s = PRE;
        end else begin
            eob_state_s = IDLE;
        end
        if (burst_len_r != LEN_ZERO) begin
            pre_next_s = PAY;
        end else if (gap_len_r != LEN_ZERO) begin
            pre_next_s = GAP;
        end else begin
            pre_next_s = eob_state_s;
        end
        if (gap_len_r != LEN_ZERO) begin
            pay_next_s = GAP;
        end else begin
            pay_next_s = eob_state_s;
        end
    end

    // Sequencer: phase state, symbol count, latched settings and symbol outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sym_cnt_r    <= LEN_ZERO;
            burst_len_r  <= LEN_ZERO;
            gap_len_r    <= LEN_ZERO;
            continuous_r <= 1'b0;
            o_sym        <= 1'b0;
            o_sym_valid  <= 1'b0;
            o_sym_is_pre <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_sym_valid <= 1'b0;
            o_done      <= 1'b0;
            if (i_abort && (state_r != IDLE)) begin
                state_r      <= IDLE;
                sym_cnt_r    <= LEN_ZERO;
                o_sym        <= 1'b0;
                o_sym_is_pre <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_ok_s) begin
                            burst_len_r  <= i_burst_len;
                            gap_len_r    <= i_gap_len;
                            continuous_r <= i_continuous;
                            sym_cnt_r    <= LEN_ZERO;
                            state_r      <= PRE;
                        end
                    end
                    PRE: begin
                        if (tick_s) begin
                            o_sym        <= ~sym_cnt_r[0];
                            o_sym_valid  <= 1'b1;
                            o_sym_is_pre <= 1'b1;
                            if (sym_cnt_r == PRE_LAST) begin
                                state_r   <= pre_next_s;
                                sym_cnt_r <= LEN_ZERO;
                                o_done    <= (pre_next_s == IDLE);
                            end else begin
                                sym_cnt_r <= sym_cnt_r + LEN_ONE;
                            end
                        end
                    end
                    PAY: begin
                        if (tick_s) begin
                            o_sym        <= i_prbs;
                            o_sym_valid  <= 1'b1;
                            o_sym_is_pre <= 1'b0;
                            if (sym_cnt_r == burst_len_r - LEN_ONE) begin
                                state_r   <= pay_next_s;
                                sym_cnt_r <= LEN_ZERO;
                                o_done    <= (pay_next_s == IDLE);
                            end else begin
                                sym_cnt_r <= sym_cnt_r + LEN_ONE;
                            end
                        end
                    end
                    GAP: begin
                        o_sym <= 1'b0;
                        if (tick_s) begin
                            if (sym_cnt_r == gap_len_r - LEN_ONE) begin
                                state_r   <= eob_state_s;
                                sym_cnt_r <= LEN_ZERO;
                                o_done    <= !continuous_r;
                            end else begin
                                sym_cnt_r <= sym_cnt_r + LEN_ONE;
                            end
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        sym_cnt_r <= LEN_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/prbs_burst_ctrl.md
Name: prbs_burst_ctrl

Overview:
Sequencer for the 5-bit PRBS test-pattern generator in the timing-recovery transmit path. It produces the generator's symbol-rate enable, frames each burst as an alternating preamble, a PRBS payload and an idle gap, and presents one symbol per symbol period to the modulator/upsampler. It supports one-shot bursts and continuous repetition, plus abort.

Parameters:
OS, 4, clock cycles per symbol; must be at least 2.
PRE_LEN, 8, preamble symbols; must be at least 1; pattern 1,0,1,0,...
LEN_W, 16, width of the burst and gap length inputs and of the symbol counter.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
i_start  in  1  start request; honoured only in IDLE
i_abort  in  1  abort the current burst; returns to IDLE
i_continuous  in  1  repeat preamble/payload/gap until aborted; latched at start
i_burst_len  in  LEN_W  payload symbol count; latched at start
i_gap_len  in  LEN_W  gap symbol count; latched at start
i_prbs  in  1  generator output bit (prbs_out)
o_gen_en  out  1  generator enable (to i_en); one-cycle pulse per payload symbol
o_sym  out  1  current symbol bit
o_sym_valid  out  1  one-cycle strobe, one per preamble or payload symbol
o_sym_is_pre  out  1  qualifies o_sym_valid as a preamble symbol
o_busy  out  1  high whenever state is not IDLE
o_done  out  1  one-cycle pulse on normal completion of a non-continuous burst
o_sym_cnt  out  LEN_W  symbols emitted in the current phase

Behaviour:
- Reset values: state IDLE, divider 0, all outputs 0, latched lengths 0.
- States: IDLE, PRE, PAY, GAP.
- Divider: runs only when not IDLE, counts 0..OS-1. tick = (div==OS-1). Cleared to 0 on start acceptance.
- Start: i_start=1 && i_abort=0 in IDLE at edge E0. Latch lengths and continuous; state becomes PRE; sym_cnt becomes 0.
- First o_sym_valid is high in the cycle after edge E(OS). Subsequent strobes follow every OS cycles.
- Output registers: o_sym, o_sym_valid and o_sym_is_pre are registered and update on the edge that ends a tick cycle.
- PRE: each tick emits bit = ~sym_cnt[0], giving 1,0,1,0,... After PRE_LEN symbols:
  - go to PAY if burst_len>0;
  - else GAP if gap_len>0;
  - else end-of-burst.
- PAY:
  - o_gen_en = tick && state==PAY. It is combinational from registers only and must not depend on inputs.
  - On that tick, o_sym takes the current i_prbs; the generator advances on the same edge.
  - After burst_len symbols, go to GAP, or to end-of-burst if gap_len==0.
- GAP: ticks counted, no o_sym_valid, o_sym forced to 0. After gap_len ticks, go to end-of-burst.
- End-of-burst:
  - continuous=1: go to PRE, no o_done. The divider keeps running, so the symbol cadence is unbroken.
  - continuous=0: go to IDLE and pulse o_done on that same edge; o_busy falls on that edge.
- sym_cnt: resets to 0 on each phase change. LEN_W width; lengths up to 2^LEN_W-1 are supported, with no wrap inside a phase.
- Abort:
  - i_abort=1 at any edge while not IDLE: go to IDLE, clear divider, o_sym_valid and o_sym; no o_done.
  - If an o_gen_en pulse coincides with abort, the generator still advances. That is acceptable; no reseed is performed.
- Simultaneous i_start and i_abort in IDLE: abort wins, state stays IDLE.
- i_start while busy: ignored. Length inputs are ignored after latch.
- Reset mid-burst: immediate IDLE and all outputs 0, independent of clk.

Decomposition:
- Package prbs_pkg holds:
  - the state enum {IDLE, PRE, PAY, GAP};
  - the default OS, PRE_LEN and LEN_W constants;
  - PRBS5_SEED = 5'b00001 for the benches.
- One natural sub-module: sym_tick_div. It is an OS-cycle divider with clear and enable, and outputs tick.
- The PRBS generator stays a separate instance at top level; this block does not contain the LFSR.

Test Plan:
- Basic burst. Generator freshly reset; OS=4, PRE_LEN=8, burst 7, gap 3, continuous 0; start at E0.
  -> 15 o_sym_valid strobes 4 cycles apart, the first after E4.
  -> o_sym = 1,0,1,0,1,0,1,0 (o_sym_is_pre=1), then 1,0,0,1,0,1,1.
  -> exactly 7 o_gen_en pulses.
  -> o_done pulses once 12 cycles after the last payload strobe edge; o_busy then falls.
- Zero lengths. burst 0, gap 0 -> 8 preamble strobes only, 0 o_gen_en, o_done on the 8th tick edge.
- Continuous mode. burst 3, gap 2, continuous 1, run 3 cycles of the pattern.
  -> preamble repeats with no cadence break (every strobe exactly 4 cycles apart, gap slots excepted).
  -> no o_done; payload continues the PRBS sequence across bursts.
- Abort. Abort during PAY symbol 2 -> next edge IDLE, o_busy=0, no further strobes or o_gen_en, no o_done. A new start then begins with preamble symbol 1.
- Start rules. Start while busy -> no effect on count or timing. Start and abort together in IDLE -> stays IDLE.
- Async reset. Assert rst mid-gap between clock edges -> outputs 0 immediately. After release, a start reproduces the scenario-1 sequence if the generator is also reset.
